// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path types: the 16-bit instruction parcel and the
// compressed-encoding test used by the aligner.
package riscv_fetch_pkg;

  localparam int unsigned ParcelBits = 16;

  typedef logic [ParcelBits-1:0] parcel_t;

  function automatic logic is_compressed(input parcel_t p);
    return p[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_buffer_parcel_fifo.sv
// Circular parcel store: pushes and pops one or two parcels per cycle and
// exposes the two oldest parcels for decode.
module parcel_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrBits = $clog2(Depth),
  localparam int unsigned CntBits = PtrBits + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [1:0]         push_cnt_i,
  input  parcel_t            push_lo_i,
  input  parcel_t            push_hi_i,
  input  logic [1:0]         pop_cnt_i,
  output parcel_t            p0_o,
  output parcel_t            p1_o,
  output logic [CntBits-1:0] count_o
);

  parcel_t              mem_q [Depth];
  logic [PtrBits-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrBits-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntBits-1:0]   count_q, count_d;

  // pointer and occupancy update; caller guarantees space for any push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrBits'(push_cnt_i);
      rd_ptr_d = rd_ptr_q + PtrBits'(pop_cnt_i);
      count_d  = count_q + CntBits'(push_cnt_i) - CntBits'(pop_cnt_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_cnt_i != 2'd0) mem_q[wr_ptr_q] <= push_lo_i;
    if (push_cnt_i == 2'd2) mem_q[wr_ptr_q + PtrBits'(1'b1)] <= push_hi_i;
  end

  assign p0_o    = mem_q[rd_ptr_q];
  assign p1_o    = mem_q[rd_ptr_q + PtrBits'(1'b1)];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch front end: issues word reads, tracks in-flight/stale responses and
// hands out one aligned (32-bit or compressed) instruction per handshake.
module fetch_align_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned        RegBits        = 32,
  parameter int unsigned        DepthParcels   = 8,
  parameter int unsigned        MaxOutstanding = 2,
  parameter logic [RegBits-1:0] ResetPc        = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               redirect_i,
  input  logic [RegBits-1:0] redirect_pc_i,
  output logic               mem_req_o,
  output logic [RegBits-1:0] mem_addr_o,
  input  logic               mem_ready_i,
  input  logic               mem_rvalid_i,
  input  logic [31:0]        mem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [31:0]        instr_o,
  output logic [RegBits-1:0] instr_pc_o,
  output logic               instr_compressed_o
);

  localparam int unsigned CntBits = $clog2(DepthParcels) + 1;
  localparam int unsigned OutBits = $clog2(MaxOutstanding + 1);
  localparam logic [RegBits-1:0] HalfMask = {{(RegBits-1){1'b1}}, 1'b0};
  localparam logic [RegBits-1:0] WordMask = {{(RegBits-2){1'b1}}, 2'b00};

  logic [RegBits-1:0] fetch_addr_q, fetch_addr_d;
  logic [RegBits-1:0] head_pc_q, head_pc_d;
  logic [OutBits-1:0] inflight_q, inflight_d, inflight_next_s;
  logic [OutBits-1:0] drop_q, drop_d;
  logic               skip_low_q, skip_low_d;

  logic [CntBits-1:0] count_s;
  parcel_t            p0_s, p1_s, push_lo_s, push_hi_s;
  logic [1:0]         push_cnt_s, pop_cnt_s;
  logic [31:0]        need_s;
  logic               accept_s, fire_s;

  parcel_fifo #(.Depth(DepthParcels)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_i),
    .push_cnt_i (push_cnt_s),
    .push_lo_i  (push_lo_s),
    .push_hi_i  (push_hi_s),
    .pop_cnt_i  (pop_cnt_s),
    .p0_o       (p0_s),
    .p1_o       (p1_s),
    .count_o    (count_s)
  );

  // Reserve two parcels per live read so a response can never overflow.
  assign need_s     = 32'(count_s) + 32'd2 * (32'(inflight_q) - 32'(drop_q) + 32'd1);
  assign mem_req_o  = rst_i && !redirect_i && (32'(inflight_q) < MaxOutstanding)
                      && (need_s <= DepthParcels);
  assign mem_addr_o = fetch_addr_q;
  assign instr_pc_o = head_pc_q;
  assign accept_s   = mem_req_o && mem_ready_i;
  assign fire_s     = instr_valid_o && instr_ready_i;

  always_comb begin
    instr_valid_o      = 1'b0;
    instr_compressed_o = 1'b0;
    instr_o            = 32'h0000_0000;
    if (count_s == '0) begin
      instr_valid_o = 1'b0;
    end else if (is_compressed(p0_s)) begin
      instr_valid_o      = 1'b1;
      instr_compressed_o = 1'b1;
      instr_o            = {16'h0000, p0_s};
    end else begin
      instr_valid_o = (count_s >= CntBits'(2'd2));
      instr_o       = {p1_s, p0_s};
    end
  end

  always_comb begin
    inflight_next_s = inflight_q + OutBits'(accept_s) - OutBits'(mem_rvalid_i);
    fetch_addr_d    = fetch_addr_q;
    head_pc_d       = head_pc_q;
    inflight_d      = inflight_next_s;
    drop_d          = drop_q;
    skip_low_d      = skip_low_q;
    push_cnt_s      = 2'd0;
    pop_cnt_s       = 2'd0;
    push_lo_s       = mem_rdata_i[15:0];
    push_hi_s       = mem_rdata_i[31:16];
    if (redirect_i) begin
      // every read still outstanding after this cycle belongs to the old stream
      head_pc_d    = redirect_pc_i & HalfMask;
      fetch_addr_d = redirect_pc_i & WordMask;
      skip_low_d   = redirect_pc_i[1];
      drop_d       = inflight_next_s;
    end else begin
      if (accept_s) begin
        fetch_addr_d = fetch_addr_q + RegBits'(3'd4);
      end else begin
        fetch_addr_d = fetch_addr_q;
      end
      if (mem_rvalid_i && (drop_q != '0)) begin
        drop_d = drop_q - OutBits'(1'b1);
      end else if (mem_rvalid_i && skip_low_q) begin
        push_cnt_s = 2'd1;
        push_lo_s  = mem_rdata_i[31:16];
        skip_low_d = 1'b0;
      end else if (mem_rvalid_i) begin
        push_cnt_s = 2'd2;
      end else begin
        push_cnt_s = 2'd0;
      end
      if (fire_s) begin
        pop_cnt_s = instr_compressed_o ? 2'd1 : 2'd2;
        head_pc_d = head_pc_q + (instr_compressed_o ? RegBits'(3'd2) : RegBits'(3'd4));
      end else begin
        pop_cnt_s = 2'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_addr_q <= ResetPc & WordMask;
      head_pc_q    <= ResetPc;
      inflight_q   <= '0;
      drop_q       <= '0;
      skip_low_q   <= ResetPc[1];
    end else begin
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      skip_low_q   <= skip_low_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed and random stimulus against a sequential-PC instruction stream
// model derived from a memory image.
module tb_fetch_align_buffer;

  localparam int MaxOut = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, redirect_i, mem_req_o, mem_ready_i, mem_rvalid_i;
  logic        instr_valid_o, instr_ready_i, instr_compressed_o;
  logic [31:0] redirect_pc_i, mem_addr_o, mem_rdata_i, instr_o, instr_pc_o;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned n_hs = 0;

  logic [31:0] img [logic [31:0]];
  logic [31:0] pend_q [$];
  logic [31:0] acc_log_q [$];
  logic [31:0] hs_instr_q [$];
  logic [31:0] hs_pc_q [$];
  logic        hs_comp_q [$];
  logic [31:0] exp_pc, exp_fetch;
  logic        redir_s, mem_rdy_s, ins_rdy_s, rsp_en_s;
  logic [31:0] redir_pc_s;

  fetch_align_buffer dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .mem_req_o          (mem_req_o),
    .mem_addr_o         (mem_addr_o),
    .mem_ready_i        (mem_ready_i),
    .mem_rvalid_i       (mem_rvalid_i),
    .mem_rdata_i        (mem_rdata_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_compressed_o (instr_compressed_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (img.exists(a)) return img[a];
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EB_CA6B;
    return h ^ (h >> 13);
  endfunction

  function automatic logic [15:0] parcel_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_hs(input string tag, input int idx, input logic [31:0] ins,
                        input logic [31:0] pc, input logic comp);
    chk({tag, "_present"}, {31'd0, hs_pc_q.size() > idx}, 32'd1);
    if (hs_pc_q.size() > idx) begin
      chk({tag, "_instr"}, hs_instr_q[idx], ins);
      chk({tag, "_pc"}, hs_pc_q[idx], pc);
      chk({tag, "_comp"}, {31'd0, hs_comp_q[idx]}, {31'd0, comp});
    end
  endtask

  task automatic clear_logs();
    acc_log_q.delete();
    hs_instr_q.delete();
    hs_pc_q.delete();
    hs_comp_q.delete();
  endtask

  // One clock: drive, check against the stream model, advance memory and model.
  task automatic cycle();
    logic acc, hs, rsp, ec;
    logic [15:0] p0;
    logic [31:0] ei;
    redirect_i    = redir_s;
    redirect_pc_i = redir_pc_s;
    mem_ready_i   = mem_rdy_s;
    instr_ready_i = ins_rdy_s;
    rsp           = rsp_en_s && (pend_q.size() > 0);
    mem_rvalid_i  = rsp;
    if (rsp) mem_rdata_i = mem_word(pend_q[0]);
    else     mem_rdata_i = $urandom;
    #1;
    acc = mem_req_o && mem_ready_i;
    hs  = instr_valid_o && instr_ready_i && !redirect_i && rst_i;
    if (!rst_i || redirect_i) chk("req_blocked", {31'd0, mem_req_o}, 32'd0);
    else if (mem_req_o) chk("inflight_limit", {31'd0, pend_q.size() < MaxOut}, 32'd1);
    if (acc) begin
      chk("fetch_addr", mem_addr_o, exp_fetch);
      acc_log_q.push_back(mem_addr_o);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (hs) begin
      p0 = parcel_at(exp_pc);
      ec = (p0[1:0] != 2'b11);
      ei = ec ? {16'h0000, p0} : {parcel_at(exp_pc + 32'd2), p0};
      chk("instr_pc", instr_pc_o, exp_pc);
      chk("instr", instr_o, ei);
      chk("compressed", {31'd0, instr_compressed_o}, {31'd0, ec});
      hs_instr_q.push_back(instr_o);
      hs_pc_q.push_back(instr_pc_o);
      hs_comp_q.push_back(instr_compressed_o);
      exp_pc = exp_pc + (ec ? 32'd2 : 32'd4);
      n_hs++;
    end
    if (redirect_i && rst_i) begin
      exp_pc    = redirect_pc_i & ~32'd1;
      exp_fetch = redirect_pc_i & ~32'd3;
      clear_logs();
    end
    if (rsp) void'(pend_q.pop_front());
    if (acc) pend_q.push_back(mem_addr_o);
    @(posedge clk_i);
    #1;
    if (!rst_i) begin
      pend_q.delete();
      exp_pc    = 32'd0;
      exp_fetch = 32'd0;
      clear_logs();
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    cycle();
    cycle();
    rst_i = 1'b1;
  endtask

  initial begin
    int unsigned hs_base;
    rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0; mem_ready_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0; instr_ready_i = 1'b0;
    redir_s = 1'b0; redir_pc_s = 32'd0; mem_rdy_s = 1'b1; ins_rdy_s = 1'b1; rsp_en_s = 1'b1;
    exp_pc = 32'd0; exp_fetch = 32'd0;

    img[32'h0] = 32'h0050_0093;
    do_reset();
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
    chk("rst_comp", {31'd0, instr_compressed_o}, 32'd0);

    repeat (6) cycle();
    chk("t1_log", {31'd0, acc_log_q.size() > 0}, 32'd1);
    if (acc_log_q.size() > 0) chk("t1_addr", acc_log_q[0], 32'd0);
    chk_hs("t1", 0, 32'h0050_0093, 32'd0, 1'b0);

    do_reset();
    img[32'h0] = 32'h0001_4501;
    repeat (6) cycle();
    chk_hs("t2a", 0, 32'h0000_4501, 32'd0, 1'b1);
    chk_hs("t2b", 1, 32'h0000_0001, 32'd2, 1'b1);

    do_reset();
    img[32'h0] = 32'h0093_4501;
    img[32'h4] = 32'h1234_0050;
    cycle();
    cycle();
    rsp_en_s = 1'b0;
    cycle();
    chk("t3_wait_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("t3_wait_pc", instr_pc_o, 32'd2);
    rsp_en_s = 1'b1;
    repeat (4) cycle();
    chk_hs("t3a", 0, 32'h0000_4501, 32'd0, 1'b1);
    chk_hs("t3b", 1, 32'h0050_0093, 32'd2, 1'b0);

    do_reset();
    img[32'h100] = 32'h4505_FFFF;
    rsp_en_s = 1'b0;
    cycle();
    cycle();
    chk("t4_limit_req", {31'd0, mem_req_o}, 32'd0);
    redir_s = 1'b1; redir_pc_s = 32'h0000_0102; rsp_en_s = 1'b1;
    cycle();
    redir_s = 1'b0;
    repeat (8) cycle();
    chk("t4_log", {31'd0, acc_log_q.size() > 0}, 32'd1);
    if (acc_log_q.size() > 0) chk("t4_addr", acc_log_q[0], 32'h0000_0100);
    chk_hs("t4", 0, 32'h0000_4505, 32'h0000_0102, 1'b1);

    do_reset();
    img.delete();
    ins_rdy_s = 1'b0;
    repeat (20) cycle();
    chk("t5_req_off", {31'd0, mem_req_o}, 32'd0);
    chk("t5_valid", {31'd0, instr_valid_o}, 32'd1);
    ins_rdy_s = 1'b1;
    repeat (40) cycle();
    chk("t5_drained", {31'd0, hs_pc_q.size() >= 10}, 32'd1);

    rsp_en_s = 1'b0;
    cycle();
    cycle();
    rst_i = 1'b0; rsp_en_s = 1'b1;
    cycle();
    chk("t6_req", {31'd0, mem_req_o}, 32'd0);
    chk("t6_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("t6_instr", instr_o, 32'd0);
    chk("t6_pc", instr_pc_o, 32'd0);
    chk("t6_comp", {31'd0, instr_compressed_o}, 32'd0);
    rst_i = 1'b1;

    hs_base = n_hs;
    for (int i = 0; i < 3000; i++) begin
      mem_rdy_s  = ($urandom_range(0, 3) != 0);
      ins_rdy_s  = ($urandom_range(0, 3) != 0);
      rsp_en_s   = ($urandom_range(0, 2) != 0);
      redir_s    = ($urandom_range(0, 39) == 0);
      redir_pc_s = $urandom_range(0, 1023);
      rst_i      = ($urandom_range(0, 499) != 0);
      cycle();
    end
    chk("rand_progress", {31'd0, (n_hs - hs_base) >= 300}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
